// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// word-alignment mask, plus the request legality check used at accept time.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_t;

  // Reserved size or an address not naturally aligned to the access size.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Little-endian lane logic: extracts/extends a load lane from a word and
// merges right-justified store data into the addressed lane(s) of a word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_store_word
);

  logic [7:0]  w_bytes [4];
  logic [7:0]  w_store_lane [4];
  logic [3:0]  w_lane_en;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign w_bytes[gi] = i_word[8*gi +: 8];
      assign w_lane_en[gi] = (i_size == SZ_WORD)
                          || ((i_size == SZ_HALF) && (i_addr_lo[1] == LANE[1]))
                          || ((i_size == SZ_BYTE) && (i_addr_lo == LANE));
      // Sub-word data is replicated across lanes so the enable alone picks the target.
      assign w_store_lane[gi] = (i_size == SZ_WORD) ? i_wdata[8*gi +: 8] :
                                (i_size == SZ_HALF) ? i_wdata[8*(gi%2) +: 8] :
                                                      i_wdata[7:0];
      assign o_store_word[8*gi +: 8] = w_lane_en[gi] ? w_store_lane[gi] : w_bytes[gi];
    end
  endgenerate

  assign w_byte = w_bytes[i_addr_lo];
  assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_load_data = 32'h0;
    case (i_size)
      SZ_BYTE: o_load_data = i_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      SZ_HALF: o_load_data = i_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      SZ_WORD: o_load_data = i_word;
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: turns CPU byte/half/word requests into single-word accesses
// on the data-memory port, doing sub-word stores as read-modify-write.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_req_bad;
  logic [ADDR_W-1:0] w_word_addr;
  logic [DATA_W-1:0] w_align_word;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_store_word;

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_req_bad   = req_is_bad(req_size, req_addr[1:0]);
  assign w_word_addr = r_addr & ADDR_W'(WORD_ALIGN_MASK);
  // LOAD aligns the live read data; RMW_WR merges into the word latched in RMW_RD.
  assign w_align_word = (r_state == ST_LOAD) ? mem_read_data : r_word;

  lsu_lane_align u_lane_align (
    .i_word      (w_align_word),
    .i_addr_lo   (r_addr[1:0]),
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .o_load_data (w_load_data),
    .o_store_word(w_store_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_read        = 1'b0;
    mem_write_en    = 1'b0;
    mem_access_addr = '0;
    mem_write_data  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_bad) begin
            w_next_state = ST_RESP;
          end else if (!req_write) begin
            w_next_state = ST_LOAD;
          end else if (req_size == SZ_WORD) begin
            w_next_state = ST_STORE;
          end else begin
            w_next_state = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        mem_read        = 1'b1;
        mem_access_addr = w_word_addr;
        w_next_state    = ST_RESP;
      end
      ST_STORE: begin
        mem_write_en    = 1'b1;
        mem_access_addr = w_word_addr;
        mem_write_data  = r_wdata;
        w_next_state    = ST_RESP;
      end
      ST_RMW_RD: begin
        mem_read        = 1'b1;
        mem_access_addr = w_word_addr;
        w_next_state    = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        mem_write_en    = 1'b1;
        mem_access_addr = w_word_addr;
        mem_write_data  = w_store_word;
        w_next_state    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (r_state == ST_RMW_RD) begin
      r_word <= mem_read_data;
    end
  end

  // Response fields update only on the edge entering RESP and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept && w_req_bad) begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b1;
      end else if (r_state == ST_LOAD) begin
        r_resp_rdata <= w_load_data;
        r_resp_err   <= 1'b0;
      end else if ((r_state == ST_STORE) || (r_state == ST_RMW_WR)) begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a small behavioural data memory.
module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [31:0] mem_read_data;

  int n_checks;
  int n_pass;

  logic [31:0] mem [0:63];
  logic        pk_we;
  logic [5:0]  pk_idx;
  logic [31:0] pk_data;
  int          wr_cnt;
  int          rd_cnt;
  int          ov_cnt;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [31:0] last_rd_addr;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_access_addr(mem_access_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_access_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_access_addr[7:2]] <= mem_write_data;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_access_addr;
      last_wr_data <= mem_write_data;
    end else if (pk_we) begin
      mem[pk_idx] <= pk_data;
    end
    if (mem_read) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= mem_access_addr;
    end
  end

  always @(negedge clk) begin
    if (mem_read && mem_write_en) ov_cnt <= ov_cnt + 1;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pk_we = 1'b1; pk_idx = a[7:2]; pk_data = d;
    @(negedge clk);
    pk_we = 1'b0;
  endtask

  // Issues one request, scrambles req_* after acceptance, and waits (bounded) for resp_valid.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output logic busy_ok);
    @(negedge clk);
    busy_ok = req_ready;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_signed = ~sg;
    req_addr = 32'hFFFF_FFFC; req_wdata = ~d;
    lat = 0; rdata = 32'hXXXX_XXXX; err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (req_ready) busy_ok = 1'b0;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (mem_read !== 1'b0 || mem_write_en !== 1'b0) $display("FAIL rst_strobes got rd=%b we=%b exp 0 0", mem_read, mem_write_en); else n_pass++;
    n_checks++; if (mem_access_addr !== 32'h0 || mem_write_data !== 32'h0) $display("FAIL rst_port got addr=%h wd=%h exp 0 0", mem_access_addr, mem_write_data); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
    n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) $display("FAIL rst_resp got v=%b d=%h e=%b exp 0 0 0", resp_valid, resp_rdata, resp_err); else n_pass++;
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] rd; logic er; logic bok; int w0;
    w0 = wr_cnt;
    run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, lat, rd, er, bok);
    $display("word store 0x40 <= deadbeef: lat=%0d err=%b", lat, er);
    n_checks++; if (lat !== 2) $display("FAIL wst_lat got %0d exp 2", lat); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 1) $display("FAIL wst_pulses got %0d exp 1", wr_cnt - w0); else n_pass++;
    n_checks++; if (last_wr_addr !== 32'h40 || last_wr_data !== 32'hDEADBEEF) $display("FAIL wst_port got %h/%h exp 00000040/deadbeef", last_wr_addr, last_wr_data); else n_pass++;
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL wst_resp got %h/%b exp 0/0", rd, er); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL wst_ready got %b exp 1", bok); else n_pass++;
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, bok);
    $display("word load 0x40: data=%h lat=%0d", rd, lat);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL wld_data got %h exp deadbeef", rd); else n_pass++;
    n_checks++; if (lat !== 2) $display("FAIL wld_lat got %0d exp 2", lat); else n_pass++;
    n_checks++; if (bok !== 1'b1) $display("FAIL wld_ready got %b exp 1", bok); else n_pass++;
  endtask

  task automatic test_subword_load();
    logic [31:0] addrs [6] = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h12};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    logic        sgns  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [6] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF,
                               32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    int lat; logic [31:0] rd; logic er; logic bok;
    poke(32'h10, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      run_req(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, rd, er, bok);
      $display("load sz=%0d sgn=%b @%h: data=%h lat=%0d", sizes[i], sgns[i], addrs[i], rd, lat);
      n_checks++; if (rd !== exps[i] || er !== 1'b0) $display("FAIL subld_%0d got %h/%b exp %h/0", i, rd, er, exps[i]); else n_pass++;
      n_checks++; if (lat !== 2) $display("FAIL subld_lat_%0d got %0d exp 2", i, lat); else n_pass++;
    end
  endtask

  task automatic test_rmw_store();
    int lat; logic [31:0] rd; logic er; logic bok; int w0; int r0; int o0;
    poke(32'h20, 32'h11223344);
    w0 = wr_cnt; r0 = rd_cnt; o0 = ov_cnt;
    run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h777777AB, lat, rd, er, bok);
    $display("byte store 0x21 <= ab: wrote %h lat=%0d", last_wr_data, lat);
    n_checks++; if (lat !== 3) $display("FAIL rmwb_lat got %0d exp 3", lat); else n_pass++;
    n_checks++; if (rd_cnt - r0 !== 1 || last_rd_addr !== 32'h20) $display("FAIL rmwb_read got %0d@%h exp 1@00000020", rd_cnt - r0, last_rd_addr); else n_pass++;
    n_checks++; if (wr_cnt - w0 !== 1 || last_wr_data !== 32'h1122AB44) $display("FAIL rmwb_write got %0d:%h exp 1:1122ab44", wr_cnt - w0, last_wr_data); else n_pass++;
    n_checks++; if (mem[8] !== 32'h1122AB44) $display("FAIL rmwb_mem got %h exp 1122ab44", mem[8]); else n_pass++;
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234CAFE, lat, rd, er, bok);
    $display("half store 0x22 <= cafe: wrote %h lat=%0d", last_wr_data, lat);
    n_checks++; if (mem[8] !== 32'hCAFEAB44) $display("FAIL rmwh_mem got %h exp cafeab44", mem[8]); else n_pass++;
    n_checks++; if (lat !== 3 || bok !== 1'b1) $display("FAIL rmwh_lat got %0d/%b exp 3/1", lat, bok); else n_pass++;
    n_checks++; if (ov_cnt !== o0) $display("FAIL rmw_overlap got %0d exp 0", ov_cnt - o0); else n_pass++;
  endtask

  task automatic test_errors();
    logic        ws [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  ss [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] as [3] = '{32'h23, 32'h22, 32'h0};
    int lat; logic [31:0] rd; logic er; logic bok; int w0; int r0;
    for (int i = 0; i < 3; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      run_req(ws[i], ss[i], 1'b1, as[i], 32'h5A5A5A5A, lat, rd, er, bok);
      $display("error req w=%b sz=%0d @%h: err=%b data=%h lat=%0d", ws[i], ss[i], as[i], er, rd, lat);
      n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_resp_%0d got %b/%h exp 1/0", i, er, rd); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL err_lat_%0d got %0d exp 1", i, lat); else n_pass++;
      n_checks++; if (wr_cnt !== w0 || rd_cnt !== r0) $display("FAIL err_noaccess_%0d got w%0d r%0d exp 0 0", i, wr_cnt - w0, rd_cnt - r0); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [31:0] rd; logic er; logic bok;
    poke(32'h30, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h99;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    n_checks++; if (mem_read !== 1'b1 || mem_access_addr !== 32'h30) $display("FAIL mid_rmwrd got %b@%h exp 1@00000030", mem_read, mem_access_addr); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if (mem_read !== 1'b0 || mem_write_en !== 1'b0 || mem_access_addr !== 32'h0) $display("FAIL async_rst_port got rd=%b we=%b a=%h exp 0 0 0", mem_read, mem_write_en, mem_access_addr); else n_pass++;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL async_rst_hs got rdy=%b v=%b exp 1 0", req_ready, resp_valid); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (mem[12] !== 32'h55667788) $display("FAIL rst_mem got %h exp 55667788", mem[12]); else n_pass++;
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er, bok);
    $display("load 0x30 after reset: data=%h lat=%0d", rd, lat);
    n_checks++; if (rd !== 32'h55667788 || lat !== 2) $display("FAIL rst_reload got %h/%0d exp 55667788/2", rd, lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exps [5] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 32'hE5E5E5E5};
    int acc_cyc [5];
    int idx; int got; int cyc; logic accepting;
    for (int k = 0; k < 5; k++) poke(32'h50 + 32'(4 * k), exps[k]);
    idx = 0; got = 0; cyc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h50; req_wdata = 32'h0;
    for (int c = 0; c < 40; c++) begin
      accepting = req_valid && req_ready;
      @(posedge clk);
      cyc++;
      if (accepting && idx < 5) begin acc_cyc[idx] = cyc; idx++; end
      @(negedge clk);
      if (resp_valid) begin
        $display("b2b resp %0d: data=%h", got, resp_rdata);
        if (got < 5) begin
          n_checks++; if (resp_rdata !== exps[got]) $display("FAIL b2b_data_%0d got %h exp %h", got, resp_rdata, exps[got]); else n_pass++;
        end
        got++;
      end
      if (idx >= 5) begin
        req_valid = 1'b0;
      end else if (req_ready) begin
        req_write = 1'b0; req_size = 2'b10; req_addr = 32'h50 + 32'(4 * idx); req_wdata = 32'h0;
      end else begin
        req_write = 1'b1; req_size = 2'b10; req_addr = 32'h50; req_wdata = 32'hBAD0BAD0;
      end
    end
    req_valid = 1'b0;
    n_checks++; if (got !== 5) $display("FAIL b2b_pulses got %0d exp 5", got); else n_pass++;
    n_checks++; if (idx !== 5) $display("FAIL b2b_accepts got %0d exp 5", idx); else n_pass++;
    for (int k = 1; k < 5; k++) begin
      if (k < idx) begin
        n_checks++; if (acc_cyc[k] - acc_cyc[k-1] !== 3) $display("FAIL b2b_spacing_%0d got %0d exp 3", k, acc_cyc[k] - acc_cyc[k-1]); else n_pass++;
      end
    end
    n_checks++; if (mem[20] !== 32'hA1A1A1A1) $display("FAIL b2b_nocorrupt got %h exp a1a1a1a1", mem[20]); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    wr_cnt = 0; rd_cnt = 0; ov_cnt = 0;
    last_wr_addr = '0; last_wr_data = '0; last_rd_addr = '0;
    pk_we = 1'b0; pk_idx = '0; pk_data = '0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_word_store_load();
    test_subword_load();
    test_rmw_store();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
